fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Stage directly downstream of fetch: takes fetch's pc, reads the synchronous instruction memory,
//  buffers {pc, insn} in a DEPTH-entry FIFO and hands entries to decode over a valid/ready handshake.
//  Drives fetch's stall input (credit-based back-pressure). Flushes all wrong-path work on mispred.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  pc           in   32  current fetch pc (fetch's registered pc)
//  mispred      in   1   redirect; same signal fetch sees
//  stall        out  1   to fetch: hold pc this cycle
//  imem_en      out  1   imem read enable
//  imem_addr    out  32  imem read address (= pc)
//  imem_rdata   in   32  imem read data, valid 1 cycle after imem_en
//  deq_valid    out  1   FIFO head valid
//  deq_ready    in   1   decode accepts head
//  deq_pc       out  32  head pc
//  deq_insn     out  32  head instruction
//  deq_is_ctrl  out  1   head is control-flow (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FIFO empty, count=0, in-flight flag inf_v=0; deq_valid=0, stall=0, imem_en=0; deq_* data don't-care.
//  - issue = !reset && !stall && !mispred. imem_en=issue; imem_addr=pc (combinational).
//  - On issue: inf_v<=1, inf_pc<=pc. Else inf_v<=0.
//  - Cycle after issue (inf_v=1, no mispred): push {inf_pc, imem_rdata} at FIFO tail.
//  - Latency: pc presented in cycle t -> deq_valid with that pc in cycle t+2.
//  - Pop when deq_valid && deq_ready; deq_* show head combinationally from FIFO storage.
//  - Push and pop in same cycle: both take effect, count unchanged; legal when full (slot freed).
//  - stall = !mispred && (count + inf_v >= DEPTH). Uses registered state only (no deq_ready path);
//    guarantees push never overflows. stall forced 0 on mispred so fetch always takes the redirect.
//  - mispred (flush): count<=0, head/tail ptrs <=0, inf_v<=0, no push, no pop (deq_ready ignored),
//    no issue this cycle (pc this cycle is wrong-path). Next cycle fetch pc=commit_pc, issued normally.
//  - count width $clog2(DEPTH+1); ptrs $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
//  - Reset mid-operation: same as reset; in-flight imem data discarded.
//  - Assertions (sim only): push while count==DEPTH without pop is an error.
// CONFIGURATION
//  FETCH_QUEUE_PREDECODE_EN defined: on push, is_ctrl = opcode insn[6:0] in {JAL 7'h6f, JALR 7'h67,
//    BRANCH 7'h63}; stored per entry, driven on deq_is_ctrl.
//  Not defined: no storage for is_ctrl; deq_is_ctrl tied 0. Port list identical in both builds.
// STRUCTURE
//  - Shared package fetch_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] insn; logic is_ctrl;}
//    fq_entry_t; localparams OPC_JAL, OPC_JALR, OPC_BRANCH.
//  - One sub-module fq_fifo #(DEPTH, type T=fq_entry_t): storage, ptrs, count, push/pop/flush,
//    head data out. fetch_queue holds issue/in-flight logic, stall, predecode.
// TESTING
//  1 Reset then deq_ready=1, imem returns pc+32'h1000 as insn: deq_pc = 0,4,8,... one per cycle,
//    first deq_valid 2 cycles after reset drops, deq_insn = 32'h1000,32'h1004,...
//  2 deq_ready=0 (DEPTH=4): stall rises when count+inf_v=4; exactly 4 entries pc 0..12 held, pc frozen
//    at 16; raise deq_ready -> drains 0,4,8,12 then 16 in order, no loss/duplicate.
//  3 Full FIFO, deq_ready=1 and inf_v=1 same cycle: push+pop, count stays 4, order preserved.
//  4 mispred with 3 entries + in-flight, commit_pc=32'h200: stall=0 that cycle, next cycle deq_valid=0,
//    count=0; first dequeued pc afterwards is 32'h200, no stale pc seen.
//  5 Reset asserted mid-stream with full FIFO: next cycle deq_valid=0, stall=0; restart from pc 0.
//  6 PREDECODE_EN: insn 32'h0000006f -> deq_is_ctrl=1; 32'h00000013 -> 0; macro off -> always 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Types and opcode constants shared by the fetch queue and its FIFO.
package fetch_pkg;

   localparam logic [6:0] OPC_JAL    = 7'h6f;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        is_ctrl;
   } fq_entry_t;

   // Entry layout used when predecode is compiled out, so no is_ctrl bit is stored.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fq_entry_np_t;

   function automatic logic is_ctrl_op(input logic [31:0] insn);
      return (insn[6:0] == OPC_JAL) || (insn[6:0] == OPC_JALR) || (insn[6:0] == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/fq_fifo.sv
// Power-of-two circular FIFO with synchronous flush; head data is read combinationally.
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = fq_entry_t
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  T                             push_data,
   input  logic                         pop,
   output T                             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   T                mem_q [DEPTH];
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
      if (!reset && !flush && push) mem_q[tail_q] <= push_data;
   end

   assign head_data = mem_q[head_q];
   assign count     = count_q;

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && !flush && count_q == CntW'(DEPTH)))
      else $error("fq_fifo: push into full FIFO without pop");
`endif

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: issues imem reads, buffers {pc, insn}, credit-stalls fetch, flushes on mispred.
// Optional predecode of control-flow opcodes is enabled by defining FETCH_QUEUE_PREDECODE_EN.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        mispred,
   output logic        stall,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        deq_valid,
   input  logic        deq_ready,
   output logic [31:0] deq_pc,
   output logic [31:0] deq_insn,
   output logic        deq_is_ctrl
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned OccW = CntW + 1;

`ifdef FETCH_QUEUE_PREDECODE_EN
   typedef fq_entry_t entry_t;
`else
   typedef fq_entry_np_t entry_t;
`endif

   logic            inf_v_q, inf_v_d;
   logic [31:0]     inf_pc_q, inf_pc_d;
   logic            issue, push, pop;
   logic [CntW-1:0] count;
   logic [OccW-1:0] occ;
   entry_t          push_entry, head_entry;

   // Counting the in-flight read as occupied guarantees its push always has a free slot.
   assign occ       = {1'b0, count} + {{CntW{1'b0}}, inf_v_q};
   assign stall     = !mispred && (occ >= OccW'(DEPTH));
   assign issue     = !reset && !stall && !mispred;
   assign imem_en   = issue;
   assign imem_addr = pc;

   assign push      = inf_v_q && !mispred;
   assign deq_valid = (count != '0);
   assign pop       = deq_valid && deq_ready && !mispred;

   always_comb begin
      inf_v_d  = issue;
      inf_pc_d = issue ? pc : inf_pc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) inf_v_q <= 1'b0;
      else       inf_v_q <= inf_v_d;
      inf_pc_q <= inf_pc_d;
   end

   always_comb begin
      push_entry      = '0;
      push_entry.pc   = inf_pc_q;
      push_entry.insn = imem_rdata;
`ifdef FETCH_QUEUE_PREDECODE_EN
      push_entry.is_ctrl = is_ctrl_op(imem_rdata);
`endif
   end

   fq_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (mispred),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .count     (count)
   );

   assign deq_pc   = head_entry.pc;
   assign deq_insn = head_entry.insn;
`ifdef FETCH_QUEUE_PREDECODE_EN
   assign deq_is_ctrl = head_entry.is_ctrl;
`else
   assign deq_is_ctrl = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: fetch/imem models plus a pc scoreboard of issued fetches.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = 32'h0;
   logic        mispred = 1'b0;
   logic [31:0] commit_pc = 32'h0;
   logic        stall, imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        deq_valid;
   logic        deq_ready = 1'b0;
   logic [31:0] deq_pc, deq_insn;
   logic        deq_is_ctrl;

   logic [31:0] exp_q [$];
   logic [31:0] sb_pc;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_ctrl;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .mispred     (mispred),
      .stall       (stall),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .deq_valid   (deq_valid),
      .deq_ready   (deq_ready),
      .deq_pc      (deq_pc),
      .deq_insn    (deq_insn),
      .deq_is_ctrl (deq_is_ctrl)
   );

   function automatic logic [31:0] insn_of(input logic [31:0] a);
      case (a)
         32'h300: return 32'h0000006f;
         32'h304: return 32'h00000013;
         32'h308: return 32'h00000067;
         32'h30c: return 32'h00000063;
         default: return a + 32'h1000;
      endcase
   endfunction

   function automatic logic ctrl_of(input logic [31:0] insn);
`ifdef FETCH_QUEUE_PREDECODE_EN
      return (insn[6:0] == 7'h6f) || (insn[6:0] == 7'h67) || (insn[6:0] == 7'h63);
`else
      return 1'b0;
`endif
   endfunction

   // Fetch stage, synchronous imem, and scoreboard of pcs fetch handed over.
   always @(posedge clk) begin
      if (reset)        pc <= 32'h0;
      else if (mispred) pc <= commit_pc;
      else if (!stall)  pc <= pc + 32'h4;
      if (imem_en) imem_rdata <= insn_of(imem_addr);
      if (reset || mispred) exp_q.delete();
      else if (!stall)      exp_q.push_back(pc);
   end

   task automatic tick(input logic rst, input logic rdy, input logic mp);
      @(negedge clk);
      reset     = rst;
      deq_ready = rdy;
      mispred   = mp;
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (deq_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", deq_valid);
      else n_pass++;
      n_checks++;
      if (stall !== 1'b0) $display("FAIL reset_stall: got %b, required 0", stall);
      else n_pass++;
      n_checks++;
      if (imem_en !== 1'b0) $display("FAIL reset_imem_en: got %b, required 0", imem_en);
      else n_pass++;
   endtask

   task automatic test_stream();
      tick(1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({imem_en, imem_addr, deq_valid} !== {1'b1, 32'h0, 1'b0})
         $display("FAIL stream_c0: got en=%b addr=%h valid=%b, required en=1 addr=0 valid=0",
                  imem_en, imem_addr, deq_valid);
      else n_pass++;
      tick(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (deq_valid !== 1'b0) $display("FAIL stream_c1_valid: got %b, required 0", deq_valid);
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         n_checks++;
         if (deq_valid !== 1'b1) $display("FAIL stream_valid: got %b, required 1", deq_valid);
         else n_pass++;
         if (deq_valid && deq_ready) begin
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL stream_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         tick(1'b0, 1'b0, 1'b0);
         n_checks++;
         if ({stall, imem_en} !== {(c >= 4), (c < 4)})
            $display("FAIL bp_stall c%0d: got stall=%b en=%b, required stall=%b en=%b",
                     c, stall, imem_en, (c >= 4), (c < 4));
         else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         n_checks++;
         if (deq_valid !== 1'b1) $display("FAIL bp_drain_valid: got %b, required 1", deq_valid);
         else n_pass++;
         if (deq_valid && deq_ready) begin
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL bp_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_full_throughput();
      for (int c = 0; c < 6; c++) tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({deq_valid, stall} !== {1'b1, (i == 0)})
            $display("FAIL full_tp i%0d: got valid=%b stall=%b, required valid=1 stall=%b",
                     i, deq_valid, stall, (i == 0));
         else n_pass++;
         if (deq_valid && deq_ready) begin
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL full_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_mispred();
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 1'b0);
      commit_pc = 32'h200;
      tick(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({stall, imem_en} !== 2'b00)
         $display("FAIL mp_cycle: got stall=%b en=%b, required stall=0 en=0", stall, imem_en);
      else n_pass++;
      tick(1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({deq_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 32'h200})
         $display("FAIL mp_after: got valid=%b en=%b addr=%h, required valid=0 en=1 addr=200",
                  deq_valid, imem_en, imem_addr);
      else n_pass++;
      tick(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (deq_valid !== 1'b0) $display("FAIL mp_gap_valid: got %b, required 0", deq_valid);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (i == 0) begin
            n_checks++;
            if ({deq_valid, deq_pc} !== {1'b1, 32'h200})
               $display("FAIL mp_first: got valid=%b pc=%h, required valid=1 pc=200",
                        deq_valid, deq_pc);
            else n_pass++;
         end
         if (deq_valid && deq_ready) begin
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL mp_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < 8; c++) tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (imem_en !== 1'b0) $display("FAIL rst_mid_en: got %b, required 0", imem_en);
      else n_pass++;
      tick(1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({deq_valid, stall, imem_en, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'h0})
         $display("FAIL rst_mid_after: got valid=%b stall=%b en=%b addr=%h, required 0 0 1 0",
                  deq_valid, stall, imem_en, imem_addr);
      else n_pass++;
      tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (i == 0) begin
            n_checks++;
            if ({deq_valid, deq_pc} !== {1'b1, 32'h0})
               $display("FAIL rst_mid_first: got valid=%b pc=%h, required valid=1 pc=0",
                        deq_valid, deq_pc);
            else n_pass++;
         end
         if (deq_valid && deq_ready) begin
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL rst_mid_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
   endtask

   task automatic test_predecode();
      commit_pc = 32'h300;
      n_ctrl    = 0;
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (deq_valid && deq_ready) begin
            if (deq_is_ctrl === 1'b1) n_ctrl++;
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL predec_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
      n_checks++;
`ifdef FETCH_QUEUE_PREDECODE_EN
      if (n_ctrl != 3) $display("FAIL predec_count: got %0d, required 3", n_ctrl);
`else
      if (n_ctrl != 0) $display("FAIL predec_count: got %0d, required 0", n_ctrl);
`endif
      else n_pass++;
   endtask

   task automatic test_random_ready();
      for (int i = 0; i < 90; i++) begin
         tick(1'b0, (i >= 80) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
         n_checks++;
         if (imem_en !== !stall)
            $display("FAIL rand_issue: got en=%b stall=%b, required en=!stall", imem_en, stall);
         else n_pass++;
         if (deq_valid && deq_ready) begin
            sb_pc = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if ({deq_pc, deq_insn, deq_is_ctrl} !== {sb_pc, insn_of(sb_pc), ctrl_of(insn_of(sb_pc))})
               $display("FAIL rand_sb: got pc=%h insn=%h ctrl=%b, required pc=%h insn=%h ctrl=%b",
                        deq_pc, deq_insn, deq_is_ctrl, sb_pc, insn_of(sb_pc),
                        ctrl_of(insn_of(sb_pc)));
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_full_throughput();
      test_mispred();
      test_reset_midstream();
      test_predecode();
      test_random_ready();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
